// File: rtl/lc3_fetch_if.sv
// Fetch-unit bus: the PC-update request from the control FSM and the instruction-memory
// address port going out to the BRAM.
interface lc3_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              fetch_start;
  logic [3:0]        opCode_in;
  logic [8:0]        offset_in;
  logic [ADDR_W-1:0] reg_in;
  logic [2:0]        br_nzp;
  logic [2:0]        result_nzp;
  logic [ADDR_W-1:0] addr_out;
  logic              wea_out;
  logic [ADDR_W-1:0] pc;

  modport master (
    output fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
    input  addr_out, wea_out, pc
  );

  modport slave (
    input  fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
    output addr_out, wea_out, pc
  );
endinterface

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch / PC update: sequential, BR, JMP/RET next-PC with a registered fetch address.
// Optional macro FETCH_TRAP_EN: TRAP (1111) jumps to zero-extended trapvect8.
module lc3_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  lc3_fetch_if.slave      bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_pc;

  function automatic logic [ADDR_W-1:0] sext9(input logic [8:0] off);
    return {{(ADDR_W-9){off[8]}}, off};
  endfunction

  function automatic logic [ADDR_W-1:0] calc_next_pc(
    input logic [ADDR_W-1:0] cur_pc,
    input logic [3:0]        op,
    input logic [8:0]        off,
    input logic [ADDR_W-1:0] base_r,
    input logic [2:0]        br_cc,
    input logic [2:0]        res_cc
  );
    logic [ADDR_W-1:0] seq_pc;
    seq_pc = cur_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    case (op)
      // br_cc of 000 never intersects the condition codes, so it is never taken
      OP_BR:   calc_next_pc = ((br_cc & res_cc) != 3'b000) ? seq_pc + sext9(off) : seq_pc;
      OP_JMP:  calc_next_pc = base_r;
`ifdef FETCH_TRAP_EN
      OP_TRAP: calc_next_pc = {{(ADDR_W-8){1'b0}}, off[7:0]};
`endif
      default: calc_next_pc = seq_pc;
    endcase
  endfunction

  assign next_pc = calc_next_pc(pc_q, bus.opCode_in, bus.offset_in, bus.reg_in,
                                bus.br_nzp, bus.result_nzp);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.fetch_start) begin
          state_d = ISSUE;
          pc_d    = next_pc;
          addr_d  = next_pc;
        end
      end
      // a request arriving while the address is being presented is dropped
      ISSUE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.addr_out = addr_q;
  assign bus.wea_out  = 1'b0;

endmodule

// File: tb/tb_lc3_fetch.sv
// Scoreboard bench for lc3_fetch: expected PCs queued when a fetch is driven, popped when it lands.
module tb_lc3_fetch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [15:0] model_pc;
  logic [15:0] sb_q[$];

  lc3_fetch_if #(.ADDR_W(16)) bus ();

  lc3_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [3:0] op,
                                           input logic [8:0] off, input logic [15:0] r,
                                           input logic [2:0] br, input logic [2:0] res);
    int v;
    if (op == 4'b0000) begin
      if ((br & res) != 3'b000) v = int'(p) + 1 + int'($signed(off));
      else                      v = int'(p) + 1;
    end else if (op == 4'b1100) begin
      v = int'(r);
    end else if (op == 4'b1111) begin
`ifdef FETCH_TRAP_EN
      v = int'(off[7:0]);
`else
      v = int'(p) + 1;
`endif
    end else begin
      v = int'(p) + 1;
    end
    return 16'(v);
  endfunction

  task automatic scramble();
    bus.opCode_in  = 4'($urandom);
    bus.offset_in  = 9'($urandom);
    bus.reg_in     = 16'($urandom);
    bus.br_nzp     = 3'($urandom);
    bus.result_nzp = 3'($urandom);
  endtask

  // drive one request, check the edge it lands on and that the ISSUE cycle holds it
  task automatic do_fetch(input string tag, input logic [3:0] op, input logic [8:0] off,
                          input logic [15:0] r, input logic [2:0] br, input logic [2:0] res);
    logic [15:0] e;
    @(negedge clk);
    bus.opCode_in  = op;
    bus.offset_in  = off;
    bus.reg_in     = r;
    bus.br_nzp     = br;
    bus.result_nzp = res;
    bus.fetch_start = 1'b1;
    sb_q.push_back(ref_next(model_pc, op, off, r, br, res));
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
      e = model_pc;
    end else begin
      e = sb_q.pop_front();
    end
    chk({tag, "_pc"}, bus.pc, e);
    chk({tag, "_addr"}, bus.addr_out, e);
    chk({tag, "_wea"}, {15'b0, bus.wea_out}, 16'h0000);
    model_pc = e;
    @(negedge clk);
    bus.fetch_start = 1'b0;
    scramble();
    @(posedge clk); #1;
    chk({tag, "_hold"}, bus.pc, e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_pc = 16'h0000;
    rst_n = 1'b1;
    bus.fetch_start = 1'b0;
    bus.opCode_in   = 4'b0001;
    bus.offset_in   = 9'h000;
    bus.reg_in      = 16'h0000;
    bus.br_nzp      = 3'b000;
    bus.result_nzp  = 3'b000;

    // reset held 5 cycles; a request during reset must be ignored
    repeat (4) @(posedge clk);
    @(negedge clk); bus.fetch_start = 1'b1; bus.opCode_in = 4'b1100; bus.reg_in = 16'h1234;
    @(posedge clk); #1;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_addr", bus.addr_out, 16'h0000);
    @(negedge clk); rst_n = 1'b0; bus.fetch_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scramble();
      @(posedge clk); #1;
      chk("idle_pc", bus.pc, 16'h0000);
      chk("idle_addr", bus.addr_out, 16'h0000);
      chk("idle_wea", {15'b0, bus.wea_out}, 16'h0000);
      @(negedge clk);
    end

    do_fetch("add1", 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    chk("add1_lit", bus.pc, 16'h0001);
    do_fetch("add2", 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    chk("add2_lit", bus.pc, 16'h0002);
    do_fetch("br_tk", 4'b0000, 9'h005, 16'h0000, 3'b010, 3'b010);
    chk("br_tk_lit", bus.pc, 16'h0008);
    do_fetch("br_nt", 4'b0000, 9'h005, 16'h0000, 3'b010, 3'b100);
    chk("br_nt_lit", bus.pc, 16'h0009);
    do_fetch("br_neg", 4'b0000, 9'h1FE, 16'h0000, 3'b111, 3'b001);
    chk("br_neg_lit", bus.pc, 16'h0008);
    do_fetch("br_000", 4'b0000, 9'h0F0, 16'h0000, 3'b000, 3'b111);
    chk("br_000_lit", bus.pc, 16'h0009);
    do_fetch("jmp", 4'b1100, 9'h000, 16'h3000, 3'b000, 3'b000);
    chk("jmp_lit", bus.pc, 16'h3000);
    do_fetch("jmp_ff", 4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000);
    do_fetch("wrap", 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    chk("wrap_lit", bus.pc, 16'h0000);
    do_fetch("neg_wrap", 4'b0000, 9'h1FE, 16'h0000, 3'b100, 3'b100);
    chk("neg_wrap_lit", bus.pc, 16'hFFFF);

    // two consecutive request cycles advance the PC only once
    @(negedge clk);
    bus.opCode_in = 4'b0001; bus.fetch_start = 1'b1;
    sb_q.push_back(ref_next(model_pc, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000));
    @(posedge clk); #1;
    model_pc = sb_q.pop_front();
    chk("dbl_first", bus.pc, model_pc);
    @(posedge clk); #1;
    chk("dbl_second", bus.pc, model_pc);
    chk("dbl_lit", bus.pc, 16'h0000);
    @(negedge clk); bus.fetch_start = 1'b0;
    @(posedge clk);

    do_fetch("pre_rst", 4'b1100, 9'h000, 16'h0042, 3'b000, 3'b000);
    // reset landing in ISSUE beats a pending request
    @(negedge clk);
    bus.opCode_in = 4'b1100; bus.reg_in = 16'h5555; bus.fetch_start = 1'b1;
    @(posedge clk); #1;
    chk("iss_pc", bus.pc, 16'h5555);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_iss_pc", bus.pc, 16'h0000);
    chk("rst_iss_addr", bus.addr_out, 16'h0000);
    @(negedge clk); rst_n = 1'b0; bus.fetch_start = 1'b0;
    model_pc = 16'h0000;

    do_fetch("post_rst", 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    do_fetch("trap", 4'b1111, 9'h125, 16'h0000, 3'b000, 3'b000);
`ifdef FETCH_TRAP_EN
    chk("trap_lit", bus.pc, 16'h0025);
`else
    chk("trap_lit", bus.pc, 16'h0002);
`endif

    chk("sb_left", 16'(sb_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
